alu_mw_sequencer: RTL and testbench

- Sequences one shared alu64bit instance to execute wide operations, NOR/XOR/ADD/SUB over WORDS×64-bit operands, one 64-bit word per step, LSB word first.
- Carry is chained between words in a register.
- Sits between a valid/ready command source and a valid/ready result sink.
- The ALU is combinational with gate delays; the sequencer allows SETTLE cycles per word before sampling.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu64bit.sv | 68 ++++++
 rtl/alu_mw_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_alu_mw_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-word ALU sequencer.
//   alu_op_t    : 2-bit ALU operation encoding.
//   seq_state_t : sequencer control states.
//   is_arith()  : true for operations that produce and consume a carry.
// SUB convention: the ALU computes a + ~b + cin, so cin=1 gives a true
// a-b and cout=1 means "no borrow" out of the word.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_NOR = 2'b00,
        OP_XOR = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } seq_state_t;

    localparam int unsigned WORD_W = 64;

    function automatic logic is_arith(input alu_op_t op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu64bit.sv
// 64-bit combinational ALU: NOR, XOR, ADD, SUB (a + ~b + cin).
// Ports:
//   a, b  in  64  operands
//   cin   in  1   carry-in (used by ADD/SUB only)
//   op    in  2   operation (alu_op_t)
//   s     out 64  result
//   cout  out 1   carry-out for ADD/SUB, 0 for logic operations
// The gate-delay parameters B..G describe the gate-level timing of this
// block; the RTL view is zero-delay and the sequencer's SETTLE cycles
// cover the real propagation time.
module alu64bit
    import alu_pkg::*;
#(
    parameter int B = 10,
    parameter int C = 6,
    parameter int D = 6,
    parameter int E = 3,
    parameter int F = 1,
    parameter int G = 8
) (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    input  alu_op_t     op,
    output logic [63:0] s,
    output logic        cout
);

    localparam int PATH_DELAY = B + C + D + E + F + G;

    // Negative total delay has no meaning; no hardware is generated either way.
    if (PATH_DELAY < 0) begin : g_negative_delay
    end

    logic [64:0] sum_s;

    // Operation decode; ADD and SUB share one 65-bit adder, SUB inverts b.
    always_comb begin
        sum_s = 65'd0;
        s     = 64'd0;
        cout  = 1'b0;
        case (op)
            OP_NOR: begin
                s    = ~(a | b);
                cout = 1'b0;
            end
            OP_XOR: begin
                s    = a ^ b;
                cout = 1'b0;
            end
            OP_ADD: begin
                sum_s = {1'b0, a} + {1'b0, b} + {64'd0, cin};
                s     = sum_s[63:0];
                cout  = sum_s[64];
            end
            OP_SUB: begin
                sum_s = {1'b0, a} + {1'b0, ~b} + {64'd0, cin};
                s     = sum_s[63:0];
                cout  = sum_s[64];
            end
            default: begin
                s    = 64'd0;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_mw_sequencer.sv
// Multi-word ALU sequencer: runs one shared alu64bit across WORDS 64-bit
// words, LSB word first, chaining the carry through a register.
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   in_valid/in_ready    command handshake (in_ready registered from state)
//   in_op, in_cin        operation and word-0 carry-in
//   in_a, in_b           64*WORDS-bit operands
//   out_valid/out_ready  result handshake
//   out_s, out_cout      64*WORDS-bit result, carry out of the top word
// Each word holds the ALU inputs for SETTLE cycles before sampling, so a
// command takes WORDS*SETTLE cycles from accept to out_valid.
module alu_mw_sequencer
    import alu_pkg::*;
#(
    parameter int WORDS  = 4,
    parameter int SETTLE = 1,
    parameter int B      = 10,
    parameter int C      = 6,
    parameter int D      = 6,
    parameter int E      = 3,
    parameter int F      = 1,
    parameter int G      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_op,
    input  logic                  in_cin,
    input  logic [64*WORDS-1:0]   in_a,
    input  logic [64*WORDS-1:0]   in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [64*WORDS-1:0]   out_s,
    output logic                  out_cout
);

    localparam int TOTAL_W      = 64 * WORDS;
    localparam int WORD_IDX_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int SETTLE_CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [WORD_IDX_W-1:0]   LAST_WORD   = WORD_IDX_W'(WORDS - 1);
    localparam logic [SETTLE_CNT_W-1:0] LAST_SETTLE = SETTLE_CNT_W'(SETTLE - 1);

    seq_state_t                state_r;
    seq_state_t                state_nxt_s;
    alu_op_t                   op_r;
    logic [TOTAL_W-1:0]        a_r;
    logic [TOTAL_W-1:0]        b_r;
    logic [TOTAL_W-1:0]        s_r;
    logic [WORD_IDX_W-1:0]     word_r;
    logic [SETTLE_CNT_W-1:0]   settle_r;
    logic                      carry_r;
    logic                      cout_r;
    logic                      in_ready_r;
    logic                      out_valid_r;

    logic                      accept_s;
    logic                      sample_s;
    logic                      last_word_s;
    logic                      carry_nxt_s;
    logic [63:0]               alu_a_s;
    logic [63:0]               alu_b_s;
    logic [63:0]               alu_s_s;
    logic                      alu_cout_s;

    assign accept_s    = in_valid && in_ready_r && (state_r == IDLE);
    assign sample_s    = (state_r == RUN) && (settle_r == LAST_SETTLE);
    assign last_word_s = (word_r == LAST_WORD);
    // Logic operations break the carry chain so out_cout reads 0 for them.
    assign carry_nxt_s = is_arith(op_r) ? alu_cout_s : 1'b0;

    // The word counter holds outside RUN, so the ALU inputs hold too.
    assign alu_a_s = a_r[{word_r, 6'b000000} +: WORD_W];
    assign alu_b_s = b_r[{word_r, 6'b000000} +: WORD_W];

    alu64bit #(
        .B(B), .C(C), .D(D), .E(E), .F(F), .G(G)
    ) u_alu (
        .a    (alu_a_s),
        .b    (alu_b_s),
        .cin  (carry_r),
        .op   (op_r),
        .s    (alu_s_s),
        .cout (alu_cout_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (sample_s && last_word_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Datapath, counters and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r        <= OP_NOR;
            a_r         <= {TOTAL_W{1'b0}};
            b_r         <= {TOTAL_W{1'b0}};
            s_r         <= {TOTAL_W{1'b0}};
            word_r      <= {WORD_IDX_W{1'b0}};
            settle_r    <= {SETTLE_CNT_W{1'b0}};
            carry_r     <= 1'b0;
            cout_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        op_r       <= alu_op_t'(in_op);
                        a_r        <= in_a;
                        b_r        <= in_b;
                        carry_r    <= is_arith(alu_op_t'(in_op)) ? in_cin : 1'b0;
                        word_r     <= {WORD_IDX_W{1'b0}};
                        settle_r   <= {SETTLE_CNT_W{1'b0}};
                        s_r        <= {TOTAL_W{1'b0}};
                        cout_r     <= 1'b0;
                        in_ready_r <= 1'b0;
                    end
                end
                RUN: begin
                    if (sample_s) begin
                        s_r[{word_r, 6'b000000} +: WORD_W] <= alu_s_s;
                        carry_r  <= carry_nxt_s;
                        settle_r <= {SETTLE_CNT_W{1'b0}};
                        if (last_word_s) begin
                            cout_r      <= carry_nxt_s;
                            out_valid_r <= 1'b1;
                        end else begin
                            word_r <= word_r + 1'b1;
                        end
                    end else begin
                        settle_r <= settle_r + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_s     = s_r;
    assign out_cout  = cout_r;

endmodule

// File: tb/tb_alu_mw_sequencer.sv
// Bench for alu_mw_sequencer: two instances (WORDS=4/SETTLE=1 and
// WORDS=2/SETTLE=3) driven with directed and random commands and compared
// against a full-width arithmetic reference model.
module tb_alu_mw_sequencer;
    import alu_pkg::*;

    localparam int W0 = 4;
    localparam int S0 = 1;
    localparam int W1 = 2;
    localparam int S1 = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid_v  [2];
    logic [1:0]   in_op_v     [2];
    logic         in_cin_v    [2];
    logic [255:0] in_a_v      [2];
    logic [255:0] in_b_v      [2];
    logic         out_ready_v [2];

    logic         in_ready0, in_ready1;
    logic         out_valid0, out_valid1;
    logic         out_cout0, out_cout1;
    logic [255:0] out_s0;
    logic [127:0] out_s1;

    int n_checks = 0;
    int n_errors = 0;

    alu_mw_sequencer #(.WORDS(W0), .SETTLE(S0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_v[0]), .in_ready(in_ready0),
        .in_op(in_op_v[0]), .in_cin(in_cin_v[0]),
        .in_a(in_a_v[0]), .in_b(in_b_v[0]),
        .out_valid(out_valid0), .out_ready(out_ready_v[0]),
        .out_s(out_s0), .out_cout(out_cout0)
    );

    alu_mw_sequencer #(.WORDS(W1), .SETTLE(S1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_v[1]), .in_ready(in_ready1),
        .in_op(in_op_v[1]), .in_cin(in_cin_v[1]),
        .in_a(in_a_v[1][127:0]), .in_b(in_b_v[1][127:0]),
        .out_valid(out_valid1), .out_ready(out_ready_v[1]),
        .out_s(out_s1), .out_cout(out_cout1)
    );

    function automatic logic rdy(input int sel);
        return (sel == 0) ? in_ready0 : in_ready1;
    endfunction

    function automatic logic vld(input int sel);
        return (sel == 0) ? out_valid0 : out_valid1;
    endfunction

    function automatic logic [256:0] res(input int sel);
        return (sel == 0) ? {out_cout0, out_s0} : {out_cout1, 128'd0, out_s1};
    endfunction

    task automatic check(input string tag, input logic [256:0] got, input logic [256:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: whole-operand arithmetic over nw*64 bits; result {cout, s}.
    function automatic logic [256:0] ref_model(input logic [1:0] op, input logic [255:0] a,
                                               input logic [255:0] b, input logic cin, input int nw);
        logic [256:0] mask, am, bm, r;
        mask = (257'd1 << (nw * 64)) - 257'd1;
        am = {1'b0, a} & mask;
        bm = {1'b0, b} & mask;
        case (op)
            2'b00:   r = ~(am | bm) & mask;
            2'b01:   r = am ^ bm;
            2'b10:   r = am + bm + {256'd0, cin};
            default: r = am + (~bm & mask) + {256'd0, cin};
        endcase
        return {r[nw * 64], r[255:0] & mask[255:0]};
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        int k;
        k = $urandom_range(0, 5);
        if (k == 0) return {256{1'b1}};
        if (k == 1) return 256'd0;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // One full command: accept, busy-phase checks, latency, result, hold, release.
    task automatic do_cmd(input int sel, input logic [1:0] op, input logic [255:0] a,
                          input logic [255:0] b, input logic cin, input int hold);
        logic [256:0] exp;
        int lat, n, nw, ns;
        nw = (sel == 0) ? W0 : W1;
        ns = (sel == 0) ? S0 : S1;
        exp = ref_model(op, a, b, cin, nw);
        n = 0;
        while (!rdy(sel) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", {256'd0, rdy(sel)}, 257'd1);
        out_ready_v[sel] = (hold == 0);
        in_valid_v[sel] = 1'b1;
        in_op_v[sel]    = op;
        in_a_v[sel]     = a;
        in_b_v[sel]     = b;
        in_cin_v[sel]   = cin;
        @(negedge clk);
        check("busy_ready", {256'd0, rdy(sel)}, 257'd0);
        check("cleared_s", res(sel) & {1'b0, {256{1'b1}}}, 257'd0);
        // Keep in_valid high with junk operands while busy; it must be ignored.
        in_op_v[sel]  = 2'($urandom);
        in_a_v[sel]   = rnd256();
        in_b_v[sel]   = rnd256();
        in_cin_v[sel] = 1'($urandom);
        lat = 0;
        while (!vld(sel) && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        in_valid_v[sel] = 1'b0;
        check("latency", 257'(lat), 257'(nw * ns));
        check("result", res(sel), exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", {256'd0, vld(sel)}, 257'd1);
            check("hold_result", res(sel), exp);
            check("hold_ready", {256'd0, rdy(sel)}, 257'd0);
        end
        out_ready_v[sel] = 1'b1;
        @(negedge clk);
        check("release_valid", {256'd0, vld(sel)}, 257'd0);
        check("release_ready", {256'd0, rdy(sel)}, 257'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            in_valid_v[i]  = 1'b0;
            in_op_v[i]     = 2'b00;
            in_cin_v[i]    = 1'b0;
            in_a_v[i]      = 256'd0;
            in_b_v[i]      = 256'd0;
            out_ready_v[i] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready0", {256'd0, in_ready0}, 257'd1);
        check("rst_valid0", {256'd0, out_valid0}, 257'd0);
        check("rst_res0", res(0), 257'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready1", {256'd0, in_ready1}, 257'd1);
        check("post_rst_valid1", {256'd0, out_valid1}, 257'd0);
        check("post_rst_res1", res(1), 257'd0);

        // Directed cases on the 4-word instance.
        do_cmd(0, 2'b10, {256{1'b1}}, 256'd1, 1'b0, 0);
        do_cmd(0, 2'b11, 256'd1 << 64, 256'd1, 1'b1, 0);
        do_cmd(0, 2'b01, {64{4'hA}}, {256{1'b1}}, 1'b1, 2);
        do_cmd(0, 2'b00, {64{4'hA}}, {256{1'b1}}, 1'b1, 0);
        do_cmd(0, 2'b10, rnd256(), rnd256(), 1'b1, 10);

        // Reset in the middle of RUN (word 2) discards the partial result.
        out_ready_v[0] = 1'b1;
        in_valid_v[0] = 1'b1;
        in_op_v[0]    = 2'b00;
        in_a_v[0]     = 256'd0;
        in_b_v[0]     = 256'd0;
        in_cin_v[0]   = 1'b0;
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {256'd0, out_valid0}, 257'd0);
        check("midrst_ready", {256'd0, in_ready0}, 257'd1);
        check("midrst_res", res(0), 257'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < W0 + 2; i++) begin
            @(negedge clk);
            check("midrst_no_valid", {256'd0, out_valid0}, 257'd0);
        end
        do_cmd(0, 2'b10, rnd256(), rnd256(), 1'b0, 0);

        // Random traffic, 4-word instance.
        for (int i = 0; i < 60; i++) begin
            do_cmd(0, 2'($urandom), rnd256(), rnd256(), 1'($urandom), $urandom_range(0, 3));
        end

        // 2-word, SETTLE=3 instance: directed ADD then random back-to-back traffic.
        do_cmd(1, 2'b10, rnd256(), rnd256(), 1'b0, 0);
        for (int i = 0; i < 200; i++) begin
            do_cmd(1, 2'($urandom), rnd256(), rnd256(), 1'($urandom), $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
